matrix_mul_seq: RTL and testbench
=================================

# matrix_mul_seq

Sequential controller for matrix multiplication of up to 5×5 unsigned 8-bit matrices, sharing one 8×8 multiply-accumulate datapath. It accepts a start request, latches the operands and dimensions, and checks that the shapes are compatible. It then performs one MAC per cycle over the i/j/k loops and reports completion with a one-cycle done pulse. It uses the same packed matrix layout and error rules as the combinational multiplier, so it can replace it where area matters more than latency.

## Interface
- DIM_MAX, 5, maximum rows/columns; also the fixed row stride of the packed layout
- ELEM_W, 8, operand element width (unsigned)
- ACC_W, 16, result element width (unsigned, modulo 2^16)

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- a_m, a_n, b_m, b_n  in  3 each  dimensions of A (a_m×a_n) and B (b_m×b_n)
- matrixA, matrixB  in  200 each  element (r,c) at bits [(r*5+c)*8 +: 8]
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse (success or error)
- mulError  out  1  dimension error of the last request; held until the next accepted start
- c_m, c_n  out  3 each  result dimensions; 0 on error
- aMulB  out  400  element (i,j) at bits [(i*5+j)*16 +: 16]; unused entries 0

## Operation
- States: IDLE, RUN, DONE, ERR.
- IDLE, start=1: latch the dimensions, matrixA and matrixB; clear aMulB, mulError, c_m and c_n.
  - Error condition: any dimension is 0, any dimension is >5, or a_n≠b_m.
  - On error → ERR.
  - Otherwise set c_m=a_m, c_n=b_n, zero the counters i, j, k and the accumulator → RUN.
- RUN: each cycle computes acc_next = acc + A[i][k]*B[k][j].
  - The 8×8 product is 16 bits. The sum wraps modulo 2^16.
  - Iteration order: k is innermost, then j, then i.
  - If k == a_n−1: write acc_next to aMulB(i,j), clear acc, set k=0, advance j.
  - If j == b_n−1: set j=0 and advance i.
  - When the last element (i=a_m−1, j=b_n−1, k=a_n−1) is written → DONE.
  - Otherwise k increments.
- DONE: done=1 for one cycle → IDLE.
- ERR: done=1 and mulError=1 for that cycle → IDLE. mulError stays 1 in IDLE.
- start outside IDLE is ignored; it is not queued. start asserted in the DONE or ERR cycle is also ignored.
- Input buses may change freely after the accepted start; only the latched copies are used.
- aMulB, c_m, c_n and mulError hold their values in IDLE until the next accepted start.
- Partial results become visible in aMulB during RUN. Consumers use them only after done.

## Timing
- Reset values: busy=0, done=0, mulError=0, c_m=0, c_n=0, aMulB=0, state=IDLE, all counters and acc=0.
- Start is accepted at edge E0. With N = a_m·b_n·a_n:
  - RUN occupies the N cycles after E0.
  - done is high during cycle N+1.
  - busy is high for N+1 cycles.
  - Minimum N=1; maximum N=125.
- Error latency: done and mulError go high in the cycle after E0; busy is high for that one cycle only.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle after done (throughput N+2 cycles per job).
- Reset mid-operation: outputs return to reset values immediately, asynchronously. The job is abandoned and no done is produced.

## Structure
- Package matrix_pkg holds:
  - DIM_MAX, ELEM_W, ACC_W;
  - the packed bus widths (200, 400);
  - the state enum {IDLE, RUN, DONE, ERR};
  - a function computing the element bit offset from (row, col, width).
- One sub-module, mac_unit: combinational 8×8 multiply plus 16-bit add, instantiated once.
- Counters, operand latches, result register and FSM live in matrix_mul_seq.

## Test plan
- 2×3 times 3×2, A rows [1 2 3;4 5 6], B rows [7 8;9 10;11 12] → aMulB = [58 64;139 154], c_m=2, c_n=2, done in cycle 13 after start, busy high for 13 cycles, all other entries 0.
- 1×1, A=3, B=4 → aMulB(0,0)=12, done in cycle 2, mulError=0.
- 5×5 with every element 255 → every entry 62981 (325125 mod 65536), done in cycle 126.
- a_n=3, b_m=2 (also a_m=0, and b_n=6) → done and mulError in cycle 1, busy high for 1 cycle, c_m=c_n=0, aMulB=0; mulError stays 1 until the next start.
- start pulsed during RUN, with matrixA changed at the same time, and start held through the DONE cycle → the original job's results are unchanged and no second job starts until start is seen in IDLE.
- Reset asserted mid-way through a 5×5 job (about cycle 40) → all outputs 0 immediately, no done pulse; a following 1×1 job completes correctly.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared parameters, state encoding and packed-layout helper for the
// sequential matrix multiplier.
package matrix_pkg;
    localparam int DIM_MAX = 5;
    localparam int ELEM_W  = 8;
    localparam int ACC_W   = 16;
    localparam int DIM_W   = 3;
    localparam int OP_W    = DIM_MAX * DIM_MAX * ELEM_W;   // 200
    localparam int RES_W   = DIM_MAX * DIM_MAX * ACC_W;    // 400
    localparam int OFF_W   = $clog2(RES_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    // Bit offset of element (row, col) in a packed bus with a fixed row stride of DIM_MAX.
    function automatic logic [OFF_W-1:0] elem_off(input logic [DIM_W-1:0] row,
                                                  input logic [DIM_W-1:0] col,
                                                  input int unsigned w);
        return OFF_W'((int'(row) * DIM_MAX + int'(col)) * w);
    endfunction
endpackage

// File: rtl/mac_unit.sv
// Combinational 8x8 multiply with 16-bit wrapping accumulate.
module mac_unit
    import matrix_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  acc_next
);
    logic [ACC_W-1:0] prod;

    assign prod     = ACC_W'(a) * ACC_W'(b);
    assign acc_next = acc + prod;
endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier: latches operands on start and performs one
// MAC per cycle over i/j/k, pulsing done on completion or dimension error.
module matrix_mul_seq
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] a_m,
    input  logic [DIM_W-1:0] a_n,
    input  logic [DIM_W-1:0] b_m,
    input  logic [DIM_W-1:0] b_n,
    input  logic [OP_W-1:0]  matrixA,
    input  logic [OP_W-1:0]  matrixB,
    output logic             busy,
    output logic             done,
    output logic             mulError,
    output logic [DIM_W-1:0] c_m,
    output logic [DIM_W-1:0] c_n,
    output logic [RES_W-1:0] aMulB
);
    state_t           state;
    logic [DIM_W-1:0] am, an, bn;
    logic [OP_W-1:0]  a_lat, b_lat;
    logic [DIM_W-1:0] i, j, k;
    logic [ACC_W-1:0] acc, acc_next;
    logic [OP_W-1:0]  a_sh, b_sh;
    logic             dim_err;

    localparam logic [DIM_W-1:0] DMAX = DIM_W'(DIM_MAX);

    assign dim_err = (a_m == '0) || (a_n == '0) || (b_m == '0) || (b_n == '0) ||
                     (a_m > DMAX) || (a_n > DMAX) || (b_m > DMAX) || (b_n > DMAX) ||
                     (a_n != b_m);

    // Operand select by shifting the latched bus down to the addressed element.
    assign a_sh = a_lat >> elem_off(i, k, ELEM_W);
    assign b_sh = b_lat >> elem_off(k, j, ELEM_W);

    mac_unit u_mac (
        .a        (a_sh[ELEM_W-1:0]),
        .b        (b_sh[ELEM_W-1:0]),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mulError <= 1'b0;
            c_m      <= '0;
            c_n      <= '0;
            aMulB    <= '0;
            am       <= '0;
            an       <= '0;
            bn       <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        am       <= a_m;
                        an       <= a_n;
                        bn       <= b_n;
                        a_lat    <= matrixA;
                        b_lat    <= matrixB;
                        aMulB    <= '0;
                        mulError <= dim_err;
                        c_m      <= dim_err ? '0 : a_m;
                        c_n      <= dim_err ? '0 : b_n;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        done     <= dim_err;
                        state    <= dim_err ? ERR : RUN;
                    end
                end
                RUN: begin
                    if (k == an - 1'b1) begin
                        aMulB[elem_off(i, j, ACC_W) +: ACC_W] <= acc_next;
                        acc <= '0;
                        k   <= '0;
                        if (j == bn - 1'b1) begin
                            j <= '0;
                            if (i == am - 1'b1) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        acc <= acc_next;
                        k   <= k + 1'b1;
                    end
                end
                default: begin
                    // DONE and ERR both last exactly one cycle.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed self-checking bench for matrix_mul_seq with hand-computed results.
module tb_matrix_mul_seq;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   a_m, a_n, b_m, b_n;
    logic [199:0] matrixA, matrixB;
    logic         busy, done, mulError;
    logic [2:0]   c_m, c_n;
    logic [399:0] aMulB;

    int checks = 0;
    int errors = 0;
    int done_cyc, busy_cnt, done_cnt;

    matrix_mul_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n),
        .matrixA(matrixA), .matrixB(matrixB),
        .busy(busy), .done(done), .mulError(mulError),
        .c_m(c_m), .c_n(c_n), .aMulB(aMulB)
    );

    always #5 clk = ~clk;

    function automatic logic [199:0] put_op(input logic [199:0] v, input int r, input int c,
                                            input logic [7:0] x);
        v[(r*5+c)*8 +: 8] = x;
        return v;
    endfunction

    function automatic logic [399:0] put_res(input logic [399:0] v, input int r, input int c,
                                             input logic [15:0] x);
        v[(r*5+c)*16 +: 16] = x;
        return v;
    endfunction

    // Drive a request at #1 after an edge; returns #1 into cycle 1.
    task automatic issue(input logic [2:0] am, input logic [2:0] an, input logic [2:0] bm,
                         input logic [2:0] bn, input logic [199:0] ma, input logic [199:0] mb);
        a_m = am; a_n = an; b_m = bm; b_n = bn;
        matrixA = ma; matrixB = mb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Watch a job from cycle 1 until busy drops after done.
    task automatic watch_job(input string name);
        int cyc;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0;
        for (cyc = 1; cyc <= 300; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && !busy) break;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc > 300) begin
            errors++;
            $display("FAIL %s timeout: done_cyc=%0d busy_cnt=%0d, required completion", name, done_cyc, busy_cnt);
        end
    endtask

    task automatic check_timing(input string name, input int exp_done);
        checks++;
        if (done_cyc !== exp_done) begin
            errors++; $display("FAIL %s done_cycle: got %0d, expected %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (busy_cnt !== exp_done) begin
            errors++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, exp_done);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0;
        a_m = 0; a_n = 0; b_m = 0; b_n = 0; matrixA = '0; matrixB = '0;
        #1;
        checks++;
        if ({busy, done, mulError, c_m, c_n} !== 9'd0 || aMulB !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b c_m=%0d c_n=%0d aMulB_nz=%b, expected all 0",
                     busy, done, mulError, c_m, c_n, |aMulB);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_2x3_3x2;
        logic [199:0] ma, mb;
        logic [399:0] exp_r;
        ma = '0; mb = '0; exp_r = '0;
        ma = put_op(ma,0,0,1); ma = put_op(ma,0,1,2); ma = put_op(ma,0,2,3);
        ma = put_op(ma,1,0,4); ma = put_op(ma,1,1,5); ma = put_op(ma,1,2,6);
        mb = put_op(mb,0,0,7);  mb = put_op(mb,0,1,8);
        mb = put_op(mb,1,0,9);  mb = put_op(mb,1,1,10);
        mb = put_op(mb,2,0,11); mb = put_op(mb,2,1,12);
        exp_r = put_res(exp_r,0,0,58);  exp_r = put_res(exp_r,0,1,64);
        exp_r = put_res(exp_r,1,0,139); exp_r = put_res(exp_r,1,1,154);
        issue(2, 3, 3, 2, ma, mb);
        watch_job("2x3");
        check_timing("2x3", 13);
        checks++;
        if (aMulB !== exp_r) begin
            errors++; $display("FAIL 2x3 aMulB: got %h, expected %h", aMulB, exp_r);
        end
        checks++;
        if (c_m !== 3'd2 || c_n !== 3'd2 || mulError !== 1'b0) begin
            errors++; $display("FAIL 2x3 dims: c_m=%0d c_n=%0d err=%b, expected 2 2 0", c_m, c_n, mulError);
        end
    endtask

    task automatic test_1x1(input string name);
        logic [399:0] exp_r;
        exp_r = put_res('0, 0, 0, 12);
        issue(1, 1, 1, 1, put_op('0,0,0,3), put_op('0,0,0,4));
        watch_job(name);
        check_timing(name, 2);
        checks++;
        if (aMulB !== exp_r || mulError !== 1'b0 || c_m !== 3'd1 || c_n !== 3'd1) begin
            errors++;
            $display("FAIL %s result: aMulB00=%0d err=%b c_m=%0d c_n=%0d, expected 12 0 1 1",
                     name, aMulB[15:0], mulError, c_m, c_n);
        end
    endtask

    task automatic test_5x5_max;
        logic [199:0] ma;
        logic [399:0] exp_r;
        ma = '0; exp_r = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma = put_op(ma, r, c, 8'd255);
                exp_r = put_res(exp_r, r, c, 16'd62981);
            end
        issue(5, 5, 5, 5, ma, ma);
        watch_job("5x5");
        check_timing("5x5", 126);
        checks++;
        if (aMulB !== exp_r) begin
            errors++; $display("FAIL 5x5 aMulB: got %h, expected %h", aMulB, exp_r);
        end
    endtask

    task automatic test_error(input string name, input logic [2:0] am, input logic [2:0] an,
                              input logic [2:0] bm, input logic [2:0] bn);
        issue(am, an, bm, bn, put_op('0,0,0,9), put_op('0,0,0,9));
        watch_job(name);
        check_timing(name, 1);
        checks++;
        if (mulError !== 1'b1 || c_m !== 3'd0 || c_n !== 3'd0 || aMulB !== '0) begin
            errors++;
            $display("FAIL %s outputs: err=%b c_m=%0d c_n=%0d aMulB_nz=%b, expected 1 0 0 0",
                     name, mulError, c_m, c_n, |aMulB);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mulError !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s hold: err=%b busy=%b, expected 1 0", name, mulError, busy);
        end
    endtask

    task automatic test_start_ignored;
        logic [199:0] ma, mb;
        logic [399:0] exp_r;
        int extra_busy;
        ma = '0; mb = '0; exp_r = '0;
        ma = put_op(ma,0,0,1); ma = put_op(ma,0,1,2); ma = put_op(ma,0,2,3);
        ma = put_op(ma,1,0,4); ma = put_op(ma,1,1,5); ma = put_op(ma,1,2,6);
        mb = put_op(mb,0,0,7);  mb = put_op(mb,0,1,8);
        mb = put_op(mb,1,0,9);  mb = put_op(mb,1,1,10);
        mb = put_op(mb,2,0,11); mb = put_op(mb,2,1,12);
        exp_r = put_res(exp_r,0,0,58);  exp_r = put_res(exp_r,0,1,64);
        exp_r = put_res(exp_r,1,0,139); exp_r = put_res(exp_r,1,1,154);
        issue(2, 3, 3, 2, ma, mb);
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; extra_busy = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (busy) begin
                if (cyc <= 13) busy_cnt++; else extra_busy++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 5)  begin start = 1'b1; matrixA = '0; a_m = 1; end
            if (cyc == 6)  start = 1'b0;
            if (cyc == 10) start = 1'b1;
            if (cyc == 13) start = 1'b0;
            @(posedge clk); #1;
        end
        check_timing("ignore", 13);
        checks++;
        if (aMulB !== exp_r) begin
            errors++; $display("FAIL ignore aMulB: got %h, expected %h", aMulB, exp_r);
        end
        checks++;
        if (extra_busy !== 0) begin
            errors++; $display("FAIL ignore second_job: busy cycles after done=%0d, expected 0", extra_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [199:0] ma;
        int seen_done;
        ma = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ma = put_op(ma, r, c, 8'd255);
        issue(5, 5, 5, 5, ma, ma);
        seen_done = 0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (done) seen_done++;
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, mulError, c_m, c_n} !== 9'd0 || aMulB !== '0) begin
            errors++;
            $display("FAIL reset_mid async: busy=%b done=%b err=%b c_m=%0d c_n=%0d aMulB_nz=%b, expected all 0",
                     busy, done, mulError, c_m, c_n, |aMulB);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done || busy) seen_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL reset_mid no_done: activity cycles=%0d, expected 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_2x3_3x2();
        test_1x1("1x1");
        test_5x5_max();
        test_error("err_an_bm", 3'd2, 3'd3, 3'd2, 3'd2);
        test_1x1("1x1_after_err");
        test_error("err_am0", 3'd0, 3'd2, 3'd2, 3'd2);
        test_error("err_bn6", 3'd2, 3'd2, 3'd2, 3'd6);
        test_start_ignored();
        test_reset_mid();
        test_1x1("1x1_after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
